// File: rtl/demux_1to4_reg_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
// Optional per-channel counters are enabled with `define DEMUX_CNT_EN.
package demux_1to4_reg_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output channel: holds a word from load until the consumer drains it.
// With `define DEMUX_CNT_EN it also keeps a saturating count of loads.
module demux_slot
  import demux_1to4_reg_pkg::*;
#(
  parameter int W = 3
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt_o
`endif
);

  ch_state_e      state_q;
  logic [W-1:0]   data_q;

  // A load into a FULL slot is only issued when the slot drains the same
  // cycle, so the new word simply replaces the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load_i) begin
            state_q <= FULL;
            data_q  <= data_i;
          end
        end
        FULL: begin
          if (load_i) begin
            data_q <= data_i;
          end else if (ready_i) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux: one producer, four independently back-pressured consumers.
// `define DEMUX_CNT_EN adds the per-channel accepted-word counters on cnt.
module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [SEL_W-1:0]   se,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic [NCH*W-1:0]   out_data
`ifdef DEMUX_CNT_EN
  , output logic [NCH*CNT_W-1:0] cnt
`endif
);

  logic           sel_free;
  logic           accept;
  logic [NCH-1:0] load;

  // Reset gates in_ready so the producer sees no handshake while held in reset.
  assign sel_free = ~out_valid[se] | out_ready[se];
  assign in_ready = rst_n & en & sel_free;
  assign accept   = in_valid & in_ready;
  assign load     = accept ? sel_onehot(se) : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux_slot #(
      .W(W)
`ifdef DEMUX_CNT_EN
      , .CNT_W(CNT_W)
`endif
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .ready_i (out_ready[k]),
      .data_i  (in_data),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*W +: W])
`ifdef DEMUX_CNT_EN
      , .cnt_o (cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

  // CNT_W has no effect without the counters; this only keeps it referenced.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end

endmodule
